exe_stage_pipe: RTL and testbench
=================================

Name: exe_stage_pipe

Overview:
Parametrised, registered execute stage for the ARM-subset core. It provides:
- the ALU path with forwarding muxes, Val2 generation and branch-target adder;
- an iterative multi-cycle multiplier (MUL/MLA);
- valid/ready handshakes on both sides, so it can stall upstream and absorb downstream (memory/SRAM) back-pressure.

It sits between ID/EXE and EXE/MEM and replaces the pass-through EXE stage plus the EXE/MEM register.

Parameters:
DATA_W, 32, datapath width (>=16, even)
IMM_W, 24, branch immediate width
MUL_BITS, 1, multiplier bits retired per cycle; must divide DATA_W; MUL_CYCLES = DATA_W/MUL_BITS

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept
exe_cmd  in  4  ALU op: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000
is_mul, mul_acc  in  1,1  multiply; multiply-accumulate
mem_r_en, mem_w_en  in  1,1  load/store (Val2 = zero-extended shift_operand)
pc  in  DATA_W  PC+4 of instruction
val_rn, val_rm, val_ra  in  DATA_W  register operands (val_ra = MLA addend)
alu_res_fwd, wb_data_fwd  in  DATA_W  forwarding sources
sel_src1, sel_src2  in  2  00 reg, 01 alu_res_fwd, 10 wb_data_fwd, 11 reg
imm  in  1  immediate operand
shift_operand  in  12  rotate_imm[11:8]/imm8, or shift_imm[11:7], type[6:5], Rm
signed_imm  in  IMM_W  branch offset (words)
sr  in  4  {N,Z,C,V}
out_valid  out  1  result register valid
out_ready  in  1  downstream accepts
alu_result, store_data, br_addr  out  DATA_W  registered results
status  out  4  registered {N,Z,C,V}

Behaviour:
- Reset (synchronous, active-high, on clk rising edge): out_valid=0; alu_result, store_data, br_addr, status = 0; FSM to IDLE; any multiply in progress is aborted and discarded.
- Handshake:
  - in_ready = (state==IDLE) & (~out_valid | out_ready). It is combinational and never depends on in_valid.
  - Accept = in_valid & in_ready. All operands, including forwarded values, are sampled only at accept.
  - Output register holds all fields stable while out_valid & ~out_ready.
  - out_valid drops the cycle after a transfer if there is no new result.
- Operand muxes: op1 from sel_src1; store_data = sel_src2-selected Rm.
- Val2:
  - mem access: {0, shift_operand}.
  - imm: imm8 rotated right by 2*rotate_imm, zero-extended to 32 then to DATA_W.
  - otherwise: Rm shifted by shift_imm, with types LSL/LSR/ASR/ROR.
- ALU ops:
  - ADC/SBC use sr[1].
  - SBC = op1 - val2 - ~C.
  - C = carry-out (ADD/ADC) or no-borrow (SUB/SBC).
  - V = signed overflow.
  - Logic/MOV ops: C and V keep sr.
  - N = msb; Z = result==0.
- br_addr = pc + (sign-extended signed_imm << 2), truncated to DATA_W. It is registered with every result.
- ALU path latency: accepted at edge k, out_valid=1 after edge k+1. Back-to-back throughput is 1/cycle when out_ready=1.
- Multiply FSM: IDLE -> MUL on accept with is_mul.
  - Load acc = mul_acc ? val_ra : 0; mcand = op1; mplier = store-path Rm.
  - Each MUL cycle adds MUL_BITS partial products and shifts.
  - After MUL_CYCLES cycles -> DONE.
  - DONE writes result (low DATA_W bits) when ~out_valid | out_ready, then -> IDLE. Otherwise it waits in DONE.
  - Mul status: N, Z from result; C, V = sr.
  - br_addr/store_data are captured at accept.
  - Latency: MUL_CYCLES+1 edges to out_valid when unstalled. in_ready=0 throughout MUL/DONE.
- Simultaneous output transfer and new accept: the new result replaces the old one; no bubble.

Test Plan:
1. ADD, sel 00, val_rn=5, imm=1, shift_operand=12'h0FF, in_valid=1, out_ready=1 -> after 1 edge: out_valid=1, alu_result=0x104, status=0000.
2. SUB, sel_src1=01, alu_res_fwd=3, Rm=5 (LSL 0) -> alu_result=0xFFFFFFFE, status=1000 (N=1, C=0 borrow); sel_src2=10 with wb_data_fwd=7 -> store_data=7.
3. MLA with op1=0xFFFF, Rm=0x10001, val_ra=1, MUL_BITS=1:
   - in_ready=0 for 33 cycles;
   - out_valid rises 33 edges after accept;
   - alu_result=0x00000000, status Z=1, C/V = sr.
4. Hold out_ready=0 with 3 back-to-back MOVs -> first result held stable, in_ready=0 while full; release -> results emerge in order, one per cycle.
5. signed_imm=24'hFFFFFE, pc=0x100 -> br_addr=0xF8; ADC with sr C=1, 0xFFFFFFFF+0 -> result 0, status 0110.
6. Assert rst during MUL state -> next cycle: out_valid=0, in_ready=1, all outputs 0, no result ever emitted.

Source files
------------

// File: rtl/exe_stage_pipe.sv
// Registered execute stage: operand forwarding, Val2 generation, ALU, branch target,
// and an iterative MUL/MLA unit. Valid/ready handshakes are on both sides.
module exe_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int IMM_W    = 24,
  parameter int MUL_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        exe_cmd,
  input  logic              is_mul,
  input  logic              mul_acc,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] val_rn,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [DATA_W-1:0] val_ra,
  input  logic [DATA_W-1:0] alu_res_fwd,
  input  logic [DATA_W-1:0] wb_data_fwd,
  input  logic [1:0]        sel_src1,
  input  logic [1:0]        sel_src2,
  input  logic              imm,
  input  logic [11:0]       shift_operand,
  input  logic [IMM_W-1:0]  signed_imm,
  input  logic [3:0]        sr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] br_addr,
  output logic [3:0]        status
);
  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // in_ready never looks at in_valid; the output register holds while out_valid & ~out_ready.

  localparam int MUL_CYCLES = DATA_W / MUL_BITS;
  localparam int CNT_W      = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [DATA_W-1:0] store_data_q, store_data_d;
  logic [DATA_W-1:0] br_addr_q, br_addr_d;
  logic [3:0]        status_q, status_d;
  logic [DATA_W-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        mul_cv_q, mul_cv_d;
  logic [DATA_W-1:0] mul_br_q, mul_br_d, mul_sd_q, mul_sd_d;

  logic              accept, out_free;
  logic [DATA_W-1:0] op1, rm_fwd, val2, b_op, alu_res, br_calc, partial;
  logic [31:0]       imm32, rot32;
  logic [4:0]        rot_amt, sh_amt;
  logic [DATA_W:0]   sum;
  logic              cin, use_sum, is_sub;
  logic [3:0]        alu_flags;

  assign out_free = ~out_valid_q | out_ready;
  assign in_ready = (state_q == S_IDLE) & out_free;
  assign accept   = in_valid & in_ready;

  always_comb begin
    unique case (sel_src1)
      2'b01:   op1 = alu_res_fwd;
      2'b10:   op1 = wb_data_fwd;
      default: op1 = val_rn;
    endcase
    unique case (sel_src2)
      2'b01:   rm_fwd = alu_res_fwd;
      2'b10:   rm_fwd = wb_data_fwd;
      default: rm_fwd = val_rm;
    endcase
  end

  // Val2 shifts the register-file Rm; the forwarded Rm feeds the store/multiplier path.
  always_comb begin
    imm32   = {24'b0, shift_operand[7:0]};
    rot_amt = {shift_operand[11:8], 1'b0};
    rot32   = (imm32 >> rot_amt) | (imm32 << (6'd32 - {1'b0, rot_amt}));
    sh_amt  = shift_operand[11:7];
    if (mem_r_en | mem_w_en) begin
      val2 = DATA_W'(shift_operand);
    end else if (imm) begin
      val2 = DATA_W'(rot32);
    end else begin
      unique case (shift_operand[6:5])
        2'b00:   val2 = val_rm << sh_amt;
        2'b01:   val2 = val_rm >> sh_amt;
        2'b10:   val2 = DATA_W'($signed(val_rm) >>> sh_amt);
        default: val2 = (val_rm >> sh_amt) | (val_rm << (DATA_W - int'(sh_amt)));
      endcase
    end
  end

  // Subtraction is op1 + ~val2 + cin, so the carry out is the no-borrow flag.
  always_comb begin
    is_sub  = (exe_cmd == 4'b0100) | (exe_cmd == 4'b0101);
    use_sum = is_sub | (exe_cmd == 4'b0010) | (exe_cmd == 4'b0011);
    b_op    = is_sub ? ~val2 : val2;
    unique case (exe_cmd)
      4'b0011, 4'b0101: cin = sr[1];
      4'b0100:          cin = 1'b1;
      default:          cin = 1'b0;
    endcase
    sum = {1'b0, op1} + {1'b0, b_op} + (DATA_W+1)'(cin);
    unique case (exe_cmd)
      4'b0001: alu_res = val2;
      4'b1001: alu_res = ~val2;
      4'b0010, 4'b0011, 4'b0100, 4'b0101: alu_res = sum[DATA_W-1:0];
      4'b0110: alu_res = op1 & val2;
      4'b0111: alu_res = op1 | val2;
      4'b1000: alu_res = op1 ^ val2;
      default: alu_res = '0;
    endcase
    if (use_sum) begin
      alu_flags = {alu_res[DATA_W-1], ~|alu_res, sum[DATA_W],
                   (op1[DATA_W-1] == b_op[DATA_W-1]) & (sum[DATA_W-1] != op1[DATA_W-1])};
    end else if (exe_cmd == 4'b0000 || exe_cmd > 4'b1001) begin
      alu_flags = sr;
    end else begin
      alu_flags = {alu_res[DATA_W-1], ~|alu_res, sr[1:0]};
    end
    br_calc = pc + (DATA_W'($signed(signed_imm)) << 2);
  end

  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (mplier_q[j]) partial = partial + (mcand_q << j);
    end
  end

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    alu_result_d = alu_result_q;
    store_data_d = store_data_q;
    br_addr_d    = br_addr_q;
    status_d     = status_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    cnt_d        = cnt_q;
    mul_cv_d     = mul_cv_q;
    mul_br_d     = mul_br_q;
    mul_sd_d     = mul_sd_q;

    unique case (state_q)
      S_IDLE: if (accept && is_mul) begin
        state_d  = S_MUL;
        acc_d    = mul_acc ? val_ra : '0;
        mcand_d  = op1;
        mplier_d = rm_fwd;
        cnt_d    = '0;
        mul_cv_d = sr[1:0];
        mul_br_d = br_calc;
        mul_sd_d = rm_fwd;
      end
      S_MUL: begin
        acc_d    = acc_q + partial;
        mcand_d  = mcand_q << MUL_BITS;
        mplier_d = mplier_q >> MUL_BITS;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE: if (out_free) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept && !is_mul) begin
      out_valid_d  = 1'b1;
      alu_result_d = alu_res;
      store_data_d = rm_fwd;
      br_addr_d    = br_calc;
      status_d     = alu_flags;
    end else if (state_q == S_DONE && out_free) begin
      out_valid_d  = 1'b1;
      alu_result_d = acc_q;
      store_data_d = mul_sd_q;
      br_addr_d    = mul_br_q;
      status_d     = {acc_q[DATA_W-1], ~|acc_q, mul_cv_q};
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      out_valid_q  <= 1'b0;
      alu_result_q <= '0;
      store_data_q <= '0;
      br_addr_q    <= '0;
      status_q     <= '0;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      cnt_q        <= '0;
      mul_cv_q     <= '0;
      mul_br_q     <= '0;
      mul_sd_q     <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      br_addr_q    <= br_addr_d;
      status_q     <= status_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      cnt_q        <= cnt_d;
      mul_cv_q     <= mul_cv_d;
      mul_br_q     <= mul_br_d;
      mul_sd_q     <= mul_sd_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_result = alu_result_q;
  assign store_data = store_data_q;
  assign br_addr    = br_addr_q;
  assign status     = status_q;

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Directed bench for exe_stage_pipe: ALU ops, shifts, forwarding, back-pressure,
// iterative multiply latency and reset abort, with hand-computed expectations.
module tb_exe_stage_pipe;
  localparam int DATA_W = 32;
  localparam int IMM_W  = 24;

  logic              clk, rst;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [3:0]        exe_cmd, sr, status;
  logic              is_mul, mul_acc, mem_r_en, mem_w_en, imm;
  logic [DATA_W-1:0] pc, val_rn, val_rm, val_ra, alu_res_fwd, wb_data_fwd;
  logic [1:0]        sel_src1, sel_src2;
  logic [11:0]       shift_operand;
  logic [IMM_W-1:0]  signed_imm;
  logic [DATA_W-1:0] alu_result, store_data, br_addr;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  int seen;

  exe_stage_pipe #(.DATA_W(DATA_W), .IMM_W(IMM_W), .MUL_BITS(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .exe_cmd(exe_cmd), .is_mul(is_mul), .mul_acc(mul_acc),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .pc(pc),
    .val_rn(val_rn), .val_rm(val_rm), .val_ra(val_ra),
    .alu_res_fwd(alu_res_fwd), .wb_data_fwd(wb_data_fwd),
    .sel_src1(sel_src1), .sel_src2(sel_src2), .imm(imm),
    .shift_operand(shift_operand), .signed_imm(signed_imm), .sr(sr),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .store_data(store_data), .br_addr(br_addr),
    .status(status)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    in_valid = 0; exe_cmd = 0; is_mul = 0; mul_acc = 0; mem_r_en = 0; mem_w_en = 0;
    pc = 0; val_rn = 0; val_rm = 0; val_ra = 0; alu_res_fwd = 0; wb_data_fwd = 0;
    sel_src1 = 0; sel_src2 = 0; imm = 0; shift_operand = 0; signed_imm = 0; sr = 0;
  endtask

  task automatic alu_op(input logic [3:0] cmd, input logic [DATA_W-1:0] rn, input logic [DATA_W-1:0] rm,
                        input logic im, input logic [11:0] so, input logic [3:0] flags);
    in_valid = 1; is_mul = 0; exe_cmd = cmd; val_rn = rn; val_rm = rm;
    imm = im; shift_operand = so; sr = flags; sel_src1 = 0; sel_src2 = 0;
  endtask

  initial begin
    clear_inputs();
    out_ready = 1;
    rst = 1;
    tick(); tick();
    chk("rst_out_valid", DATA_W'(out_valid), 0);
    chk("rst_alu_result", alu_result, 0);
    chk("rst_store_data", store_data, 0);
    chk("rst_br_addr", br_addr, 0);
    chk("rst_status", DATA_W'(status), 0);
    rst = 0;
    #1;
    chk("rst_in_ready", DATA_W'(in_ready), 1);

    // ADD with rotated immediate 0xFF
    alu_op(4'b0010, 32'd5, 32'h55, 1, 12'h0FF, 4'b0000);
    pc = 32'h40;
    tick();
    clear_inputs();
    chk("add_valid", DATA_W'(out_valid), 1);
    chk("add_result", alu_result, 32'h104);
    chk("add_status", DATA_W'(status), 4'b0000);
    chk("add_br", br_addr, 32'h40);
    chk("add_store", store_data, 32'h55);
    tick();
    chk("drop_valid", DATA_W'(out_valid), 0);

    // SUB with forwarded op1; store path forwarded from WB
    alu_op(4'b0100, 32'd99, 32'd5, 0, 12'h000, 4'b0000);
    sel_src1 = 2'b01; alu_res_fwd = 32'd3;
    sel_src2 = 2'b10; wb_data_fwd = 32'd7;
    tick();
    chk("sub_result", alu_result, 32'hFFFF_FFFE);
    chk("sub_status", DATA_W'(status), 4'b1000);
    chk("sub_store", store_data, 32'd7);

    // back-to-back: ASR, ROR, rotated imm MVN, EOR, mem add, SBC, ADD overflow
    alu_op(4'b0001, 32'd0, 32'h8000_0000, 0, 12'h240, 4'b0011);
    tick();
    chk("asr_result", alu_result, 32'hF800_0000);
    chk("asr_status", DATA_W'(status), 4'b1011);
    alu_op(4'b0001, 32'd0, 32'h0000_00F1, 0, 12'h260, 4'b0000);
    tick();
    chk("ror_result", alu_result, 32'h1000_000F);
    alu_op(4'b1001, 32'd0, 32'd0, 1, 12'h1FF, 4'b0001);
    tick();
    chk("mvn_result", alu_result, 32'h3FFF_FFC0);
    chk("mvn_status", DATA_W'(status), 4'b0001);
    alu_op(4'b1000, 32'hFF00_FF00, 32'h0F0F_0F0F, 0, 12'h000, 4'b0000);
    tick();
    chk("eor_result", alu_result, 32'hF00F_F00F);
    chk("b2b_valid", DATA_W'(out_valid), 1);
    alu_op(4'b0010, 32'h1000, 32'd0, 0, 12'hFFF, 4'b0000);
    mem_r_en = 1;
    tick();
    mem_r_en = 0;
    chk("mem_result", alu_result, 32'h1FFF);
    alu_op(4'b0101, 32'd5, 32'd5, 0, 12'h000, 4'b0000);
    tick();
    chk("sbc_result", alu_result, 32'hFFFF_FFFF);
    chk("sbc_status", DATA_W'(status), 4'b1000);
    alu_op(4'b0010, 32'h7FFF_FFFF, 32'd0, 1, 12'h001, 4'b0000);
    tick();
    chk("ovf_result", alu_result, 32'h8000_0000);
    chk("ovf_status", DATA_W'(status), 4'b1001);

    // branch target with negative offset; ADC carry-in
    alu_op(4'b0011, 32'hFFFF_FFFF, 32'd0, 1, 12'h000, 4'b0010);
    pc = 32'h100; signed_imm = 24'hFFFFFE;
    tick();
    clear_inputs();
    chk("br_neg", br_addr, 32'hF8);
    chk("adc_result", alu_result, 32'h0);
    chk("adc_status", DATA_W'(status), 4'b0110);
    tick();

    // MLA: 0xFFFF * 0x10001 + 1 wraps to zero
    in_valid = 1; is_mul = 1; mul_acc = 1; val_rn = 32'hFFFF; val_rm = 32'h10001;
    val_ra = 32'd1; sr = 4'b0101; pc = 32'h200; signed_imm = 24'd1;
    tick();
    clear_inputs();
    for (int i = 0; i < 33; i++) begin
      chk("mla_in_ready_low", DATA_W'(in_ready), 0);
      chk("mla_no_valid", DATA_W'(out_valid), 0);
      tick();
    end
    chk("mla_valid", DATA_W'(out_valid), 1);
    chk("mla_result", alu_result, 32'h0);
    chk("mla_status", DATA_W'(status), 4'b0101);
    chk("mla_br", br_addr, 32'h204);
    chk("mla_store", store_data, 32'h10001);
    chk("mla_in_ready_back", DATA_W'(in_ready), 1);
    tick();

    // MUL latency measured with a bounded wait
    in_valid = 1; is_mul = 1; val_rn = 32'h1234; val_rm = 32'h5678; val_ra = 32'hFFFF;
    tick();
    clear_inputs();
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("mul_latency", DATA_W'(cyc), 33);
    chk("mul_result", alu_result, 32'h0626_0060);
    chk("mul_status", DATA_W'(status), 4'b0000);
    tick();

    // back-pressure: three MOVs with out_ready low
    out_ready = 0;
    alu_op(4'b0001, 32'd0, 32'd0, 1, 12'h011, 4'b0000);
    tick();
    alu_op(4'b0001, 32'd0, 32'd0, 1, 12'h022, 4'b0000);
    #1;
    chk("bp_first", alu_result, 32'h11);
    chk("bp_in_ready", DATA_W'(in_ready), 0);
    tick();
    tick();
    chk("bp_hold", alu_result, 32'h11);
    chk("bp_hold_valid", DATA_W'(out_valid), 1);
    chk("bp_in_ready_full", DATA_W'(in_ready), 0);
    out_ready = 1;
    #1;
    chk("bp_release_ready", DATA_W'(in_ready), 1);
    tick();
    chk("bp_second", alu_result, 32'h22);
    alu_op(4'b0001, 32'd0, 32'd0, 1, 12'h033, 4'b0000);
    tick();
    clear_inputs();
    chk("bp_third", alu_result, 32'h33);
    chk("bp_third_valid", DATA_W'(out_valid), 1);
    tick();
    chk("bp_drain", DATA_W'(out_valid), 0);

    // reset in the middle of a multiply discards it
    in_valid = 1; is_mul = 1; val_rn = 32'd3; val_rm = 32'd4; pc = 32'h80;
    tick();
    clear_inputs();
    repeat (5) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("abort_valid", DATA_W'(out_valid), 0);
    chk("abort_in_ready", DATA_W'(in_ready), 1);
    chk("abort_result", alu_result, 0);
    chk("abort_store", store_data, 0);
    chk("abort_br", br_addr, 0);
    chk("abort_status", DATA_W'(status), 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("abort_no_result", DATA_W'(seen), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
